spike_arbiter: RTL and testbench
================================

SPIKE_ARBITER -- requirements
Module: spike_arbiter

Interface
REQ-001 Parameter p_width, default 8, bit width of each synaptic weight.
REQ-002 Parameter p_nin, default 4, number of event requesters sharing one synapse datapath; legal range 2..16.
REQ-003 Parameter p_gap, default 2, idle cycles enforced after each completed synapse operation; legal range 0..15.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset, sampled on the i_clk rising edge.
REQ-006 i_event  input  p_nin  one-cycle synchronous event pulses, bit k from requester k.
REQ-007 i_done  input  1  one-cycle pulse from the shared synapse when its accumulate/clear cycle has finished.
REQ-008 i_wr_en  input  1  weight register write strobe.
REQ-009 i_wr_addr  input  4  weight register index.
REQ-010 i_wr_data  input  p_width  weight value to write.
REQ-011 o_event  output  1  one-cycle event pulse to the shared synapse.
REQ-012 o_weight  output  p_width  weight presented to the synapse, valid from the o_event cycle until the end of the operation.
REQ-013 o_sel  output  4  index of the granted requester.
REQ-014 o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 o_drop  output  8  saturating count of lost events.

Function
REQ-016 A register file of p_nin weights SHALL be held; a write with i_wr_en=1 and i_wr_addr<p_nin updates the weight at the next edge, and a write with i_wr_addr>=p_nin SHALL be ignored.
REQ-017 One pending bit per requester SHALL be kept; i_event[k]=1 sets pending[k] at the next edge.
REQ-018 When i_event[k]=1 while pending[k] is already 1 and k is not being granted that cycle, the event SHALL be lost and o_drop SHALL increment, saturating at 255.
REQ-019 When several requests are lost in the same cycle, o_drop SHALL increment by one per lost event, still saturating at 255.
REQ-020 When pending[k] is being cleared by a grant and i_event[k]=1 in the same cycle, pending[k] SHALL remain 1 (the new event is queued) and nothing is counted as dropped.
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and GAP.
REQ-022 IDLE: if any pending bit is set, select g with round-robin search from ptr+1 upward, wrapping modulo p_nin; clear pending[g]; latch o_sel=g and o_weight=weight[g]; set ptr=g; go to ISSUE. Otherwise stay in IDLE.
REQ-023 ISSUE: drive o_event=1 for exactly this one cycle, then go to WAIT.
REQ-024 WAIT: hold o_sel and o_weight stable; on i_done=1 go to GAP, or go straight to IDLE when p_gap=0.
REQ-025 GAP: load a counter with p_gap-1 on entry, decrement it each cycle, and go to IDLE on the cycle the counter reads 0.
REQ-026 An i_done pulse received in IDLE, ISSUE or GAP SHALL be ignored.
REQ-027 A weight write to index o_sel during ISSUE or WAIT SHALL NOT change o_weight; the new value is used from the next grant.
REQ-028 Latency: an event sampled at edge E with the FSM in IDLE and no other requests pending SHALL produce o_event=1 in the cycle after edge E+1.
REQ-029 In IDLE, o_event SHALL be 0; o_sel and o_weight SHALL keep their last latched values.
REQ-030 Throughput: at most one grant per 3+p_gap cycles plus the synapse response time.

Reset
REQ-031 While i_rst=1 at an edge, the block SHALL set: state=IDLE, all pending bits=0, ptr=p_nin-1 (so the first search starts at index 0), all weights=0, o_event=0, o_weight=0, o_sel=0, o_busy=0, o_drop=0.
REQ-032 Reset asserted in any state SHALL abort the operation in progress at that edge; in-flight requests are discarded and o_drop is not incremented.
REQ-033 i_event and i_wr_en sampled at an edge where i_rst=1 SHALL have no effect.

Verification
REQ-034 Reset, write weight[2]=0x35, pulse i_event=0100, answer i_done 3 cycles after o_event -> o_event high for one cycle, 2 cycles after the event edge, with o_sel=2 and o_weight=0x35; o_busy stays high until p_gap cycles after i_done.
REQ-035 Pulse i_event=1111 in one cycle after reset, i_done always 1 cycle after o_event -> grants occur in order 0,1,2,3 and o_drop=0.
REQ-036 Pulse i_event[1] three times while requester 1 is pending and not granted -> o_drop=2 and requester 1 gets exactly one grant.
REQ-037 Hold the synapse so i_done never arrives and pulse i_event[0] 300 times -> o_drop=255 and stays there.
REQ-038 Assert i_rst during WAIT with requesters 1 and 3 pending -> the next cycle shows o_busy=0, o_drop=0, all weights=0, and no o_event appears without a new event.
REQ-039 With p_gap=0, use back-to-back requests -> the next o_event comes 2 cycles after i_done.

Source files
------------

// File: rtl/spike_arbiter_if.sv
// Handshake and configuration bundle between event requesters, the arbiter and the shared synapse.
interface spike_arbiter_if #(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_nin   = 4
);
    logic [p_nin-1:0]   i_event;
    logic               i_done;
    logic               i_wr_en;
    logic [3:0]         i_wr_addr;
    logic [p_width-1:0] i_wr_data;
    logic               o_event;
    logic [p_width-1:0] o_weight;
    logic [3:0]         o_sel;
    logic               o_busy;
    logic [7:0]         o_drop;

    modport master (
        output i_event, i_done, i_wr_en, i_wr_addr, i_wr_data,
        input  o_event, o_weight, o_sel, o_busy, o_drop
    );

    modport slave (
        input  i_event, i_done, i_wr_en, i_wr_addr, i_wr_data,
        output o_event, o_weight, o_sel, o_busy, o_drop
    );
endinterface

// File: rtl/spike_arbiter.sv
// Round-robin arbiter sharing one synapse datapath among p_nin event requesters,
// with per-requester weights, enforced post-operation gap and a saturating drop counter.
module spike_arbiter #(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_nin   = 4,
    parameter int unsigned p_gap   = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    spike_arbiter_if.slave bus
);
    localparam int unsigned sel_w = (p_nin > 1) ? $clog2(p_nin) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [p_nin-1:0]   pending, pending_next;
    logic [p_nin-1:0]   grant_oh, lost;
    logic [3:0]         ptr, ptr_next;
    logic [3:0]         gap_cnt, gap_cnt_next;
    logic [3:0]         grant_idx;
    logic               grant_found;
    logic [3:0]         sel_next;
    logic [p_width-1:0] weight_out_next;
    logic               event_next, busy_next;
    logic [4:0]         lost_cnt;
    logic [8:0]         drop_sum;
    logic [7:0]         drop_next;
    logic [p_width-1:0] weight [p_nin];

    // Weight register file; out-of-range addresses are discarded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < p_nin; k++) begin
                weight[k] <= '0;
            end
        end else if (bus.i_wr_en && (32'(bus.i_wr_addr) < p_nin)) begin
            weight[bus.i_wr_addr[sel_w-1:0]] <= bus.i_wr_data;
        end
    end

    // First pending requester at or after ptr+1, wrapping.
    always_comb begin : rr_search
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= p_nin; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= p_nin) begin
                idx = idx - p_nin;
            end
            if (!grant_found && pending[idx[sel_w-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = 4'(idx);
            end
        end
    end

    always_comb begin
        state_next      = state;
        ptr_next        = ptr;
        gap_cnt_next    = gap_cnt;
        sel_next        = bus.o_sel;
        weight_out_next = bus.o_weight;
        grant_oh        = '0;
        lost_cnt        = '0;

        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    grant_oh[grant_idx[sel_w-1:0]] = 1'b1;
                    ptr_next        = grant_idx;
                    sel_next        = grant_idx;
                    weight_out_next = weight[grant_idx[sel_w-1:0]];
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_done) begin
                    if (p_gap == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_GAP;
                        gap_cnt_next = 4'(p_gap - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A request colliding with its own grant is re-queued, not lost.
        lost         = bus.i_event & pending & ~grant_oh;
        pending_next = (pending & ~grant_oh) | bus.i_event;
        for (int unsigned k = 0; k < p_nin; k++) begin
            lost_cnt = lost_cnt + 5'(lost[k]);
        end
        drop_sum  = 9'(bus.o_drop) + 9'(lost_cnt);
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        event_next = (state_next == ST_ISSUE);
        busy_next  = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            pending      <= '0;
            ptr          <= 4'(p_nin - 1);
            gap_cnt      <= '0;
            bus.o_event  <= 1'b0;
            bus.o_weight <= '0;
            bus.o_sel    <= '0;
            bus.o_busy   <= 1'b0;
            bus.o_drop   <= '0;
        end else begin
            state        <= state_next;
            pending      <= pending_next;
            ptr          <= ptr_next;
            gap_cnt      <= gap_cnt_next;
            bus.o_event  <= event_next;
            bus.o_weight <= weight_out_next;
            bus.o_sel    <= sel_next;
            bus.o_busy   <= busy_next;
            bus.o_drop   <= drop_next;
        end
    end
endmodule

// File: tb/tb_spike_arbiter.sv
// Directed bench for spike_arbiter: default-gap instance plus a zero-gap instance for back-to-back timing.
module tb_spike_arbiter;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    spike_arbiter_if #(.p_width(8), .p_nin(4)) bus ();
    spike_arbiter_if #(.p_width(8), .p_nin(4)) bus0 ();

    spike_arbiter #(.p_width(8), .p_nin(4), .p_gap(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    spike_arbiter #(.p_width(8), .p_nin(4), .p_gap(0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.i_event = '0;  bus.i_done = 1'b0;  bus.i_wr_en = 1'b0;  bus.i_wr_addr = '0;  bus.i_wr_data = '0;
        bus0.i_event = '0; bus0.i_done = 1'b0; bus0.i_wr_en = 1'b0; bus0.i_wr_addr = '0; bus0.i_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advance until o_event is seen or the cycle budget runs out.
    task automatic wait_event(input int max_cyc, output logic got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            if (bus.o_event === 1'b1) got = 1'b1;
            else tick();
        end
    endtask

    // Answer the synapse one cycle after o_event (i.e. during WAIT).
    task automatic serve();
        tick();
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_event !== 1'b0) begin errors++; $display("FAIL reset_event got=%b exp=0", bus.o_event); end
        checks++; if (bus.o_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h00) begin errors++; $display("FAIL reset_weight got=%h exp=00", bus.o_weight); end
        checks++; if (bus.o_drop !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", bus.o_drop); end
        checks++; if (bus0.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", bus0.o_busy); end
    endtask

    task automatic test_single();
        logic got;
        apply_reset();
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd2; bus.i_wr_data = 8'h35;
        tick();
        bus.i_wr_en = 1'b0;
        bus.i_event = 4'b0100;
        tick();
        bus.i_event = 4'b0000;
        checks++; if (bus.o_event !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", bus.o_event); end
        tick();
        checks++; if (bus.o_event !== 1'b1) begin errors++; $display("FAIL single_event got=%b exp=1", bus.o_event); end
        checks++; if (bus.o_sel !== 4'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h35) begin errors++; $display("FAIL single_weight got=%h exp=35", bus.o_weight); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.o_busy); end
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        checks++; if (bus.o_event !== 1'b0) begin errors++; $display("FAIL single_one_cycle got=%b exp=0", bus.o_event); end
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd2; bus.i_wr_data = 8'h77;
        tick();
        bus.i_wr_en = 1'b0;
        checks++; if (bus.o_weight !== 8'h35) begin errors++; $display("FAIL single_hold_weight got=%h exp=35", bus.o_weight); end
        tick();
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_gap1 got=%b exp=1", bus.o_busy); end
        tick();
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_gap2 got=%b exp=1", bus.o_busy); end
        tick();
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_sel !== 4'd2) begin errors++; $display("FAIL single_idle_sel got=%0d exp=2", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h35) begin errors++; $display("FAIL single_idle_weight got=%h exp=35", bus.o_weight); end
        bus.i_event = 4'b0100;
        tick();
        bus.i_event = 4'b0000;
        wait_event(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_regrant_timeout got=%b exp=1", got); end
        checks++; if (bus.o_weight !== 8'h77) begin errors++; $display("FAIL single_new_weight got=%h exp=77", bus.o_weight); end
        serve();
        for (int i = 0; i < 4; i++) tick();
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd5; bus.i_wr_data = 8'hAA;
        tick();
        bus.i_wr_en = 1'b0;
        bus.i_event = 4'b0010;
        tick();
        bus.i_event = 4'b0000;
        wait_event(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL oob_timeout got=%b exp=1", got); end
        checks++; if (bus.o_sel !== 4'd1) begin errors++; $display("FAIL oob_sel got=%0d exp=1", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h00) begin errors++; $display("FAIL oob_weight got=%h exp=00", bus.o_weight); end
        serve();
    endtask

    task automatic test_round_robin();
        logic got;
        apply_reset();
        bus.i_event = 4'b1111;
        tick();
        bus.i_event = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_event(20, got);
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL rr_timeout idx=%0d got=%b exp=1", k, got); end
            checks++; if (bus.o_sel !== 4'(k)) begin errors++; $display("FAIL rr_order got=%0d exp=%0d", bus.o_sel, k); end
            serve();
        end
        checks++; if (bus.o_drop !== 8'd0) begin errors++; $display("FAIL rr_drop got=%0d exp=0", bus.o_drop); end
    endtask

    task automatic test_grant_collision();
        logic got;
        apply_reset();
        bus.i_event = 4'b0001;
        tick();
        tick();
        bus.i_event = 4'b0000;
        checks++; if (bus.o_event !== 1'b1) begin errors++; $display("FAIL coll_event got=%b exp=1", bus.o_event); end
        checks++; if (bus.o_drop !== 8'd0) begin errors++; $display("FAIL coll_drop got=%0d exp=0", bus.o_drop); end
        serve();
        wait_event(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL coll_requeue got=%b exp=1", got); end
        checks++; if (bus.o_sel !== 4'd0) begin errors++; $display("FAIL coll_sel got=%0d exp=0", bus.o_sel); end
        serve();
        checks++; if (bus.o_drop !== 8'd0) begin errors++; $display("FAIL coll_drop_end got=%0d exp=0", bus.o_drop); end
    endtask

    task automatic test_drop();
        logic got;
        int   extra;
        apply_reset();
        bus.i_event = 4'b0001;
        tick();
        bus.i_event = 4'b0000;
        tick();
        for (int n = 0; n < 3; n++) begin
            bus.i_event = 4'b0010;
            tick();
            bus.i_event = 4'b0000;
            tick();
        end
        checks++; if (bus.o_drop !== 8'd2) begin errors++; $display("FAIL drop_single got=%0d exp=2", bus.o_drop); end
        bus.i_event = 4'b1100;
        tick();
        bus.i_event = 4'b1110;
        tick();
        bus.i_event = 4'b0000;
        checks++; if (bus.o_drop !== 8'd5) begin errors++; $display("FAIL drop_multi got=%0d exp=5", bus.o_drop); end
        bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        for (int k = 1; k < 4; k++) begin
            wait_event(20, got);
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL drop_grant_timeout idx=%0d got=%b exp=1", k, got); end
            checks++; if (bus.o_sel !== 4'(k)) begin errors++; $display("FAIL drop_grant_order got=%0d exp=%0d", bus.o_sel, k); end
            serve();
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.o_event === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL drop_extra_grants got=%0d exp=0", extra); end
    endtask

    task automatic test_saturate();
        apply_reset();
        bus.i_event = 4'b0001;
        tick();
        bus.i_event = 4'b0000;
        tick();
        bus.i_event = 4'b0001;
        for (int i = 0; i < 300; i++) tick();
        bus.i_event = 4'b0000;
        checks++; if (bus.o_drop !== 8'd255) begin errors++; $display("FAIL sat_drop got=%0d exp=255", bus.o_drop); end
        bus.i_event = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        bus.i_event = 4'b0000;
        checks++; if (bus.o_drop !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", bus.o_drop); end
    endtask

    // Continues from the saturated, still-waiting state left by test_saturate.
    task automatic test_reset_abort();
        logic got;
        int   extra;
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd3; bus.i_wr_data = 8'h33;
        bus.i_event = 4'b1010;
        tick();
        bus.i_wr_en = 1'b0;
        bus.i_event = 4'b0000;
        rst = 1'b1;
        bus.i_event = 4'b0100;
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd1; bus.i_wr_data = 8'h99;
        tick();
        rst = 1'b0;
        bus.i_event = 4'b0000;
        bus.i_wr_en = 1'b0;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_drop !== 8'd0) begin errors++; $display("FAIL abort_drop got=%0d exp=0", bus.o_drop); end
        checks++; if (bus.o_event !== 1'b0) begin errors++; $display("FAIL abort_event got=%b exp=0", bus.o_event); end
        checks++; if (bus.o_sel !== 4'd0) begin errors++; $display("FAIL abort_sel got=%0d exp=0", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h00) begin errors++; $display("FAIL abort_weight got=%h exp=00", bus.o_weight); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.o_event === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL abort_spurious got=%0d exp=0", extra); end
        bus.i_event = 4'b1010;
        tick();
        bus.i_event = 4'b0000;
        wait_event(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL abort_g1_timeout got=%b exp=1", got); end
        checks++; if (bus.o_sel !== 4'd1) begin errors++; $display("FAIL abort_g1_sel got=%0d exp=1", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h00) begin errors++; $display("FAIL abort_w1 got=%h exp=00", bus.o_weight); end
        serve();
        wait_event(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL abort_g3_timeout got=%b exp=1", got); end
        checks++; if (bus.o_sel !== 4'd3) begin errors++; $display("FAIL abort_g3_sel got=%0d exp=3", bus.o_sel); end
        checks++; if (bus.o_weight !== 8'h00) begin errors++; $display("FAIL abort_w3 got=%h exp=00", bus.o_weight); end
        serve();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus0.i_event = 4'b0011;
        tick();
        bus0.i_event = 4'b0000;
        tick();
        checks++; if (bus0.o_event !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b exp=1", bus0.o_event); end
        checks++; if (bus0.o_sel !== 4'd0) begin errors++; $display("FAIL b2b_first_sel got=%0d exp=0", bus0.o_sel); end
        tick();
        bus0.i_done = 1'b1;
        tick();
        bus0.i_done = 1'b0;
        checks++; if (bus0.o_event !== 1'b0) begin errors++; $display("FAIL b2b_gap1 got=%b exp=0", bus0.o_event); end
        checks++; if (bus0.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", bus0.o_busy); end
        tick();
        checks++; if (bus0.o_event !== 1'b1) begin errors++; $display("FAIL b2b_second got=%b exp=1", bus0.o_event); end
        checks++; if (bus0.o_sel !== 4'd1) begin errors++; $display("FAIL b2b_second_sel got=%0d exp=1", bus0.o_sel); end
        tick();
        bus0.i_done = 1'b1;
        tick();
        bus0.i_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_grant_collision();
        test_drop();
        test_saturate();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
